// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, PC step and
// the fetch-side state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: sequential, PC-relative branch and pseudo-direct jump
// targets, with jump taking priority over branch. Purely combinational so a
// later pipelined fetch can reuse it unchanged.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_pc,
  input  logic [25:0]   i_instr_index,
  input  logic          i_jump,
  input  logic          i_pcsrc,
  input  logic [AW-1:0] i_signimm,
  output logic [AW-1:0] o_pcplus4,
  output logic [AW-1:0] o_next_pc
);

  logic signed [AW-1:0] w_br_off;
  logic        [AW-1:0] w_br_tgt;
  logic        [AW-1:0] w_jmp_tgt;

  // Sequential successor; wraps naturally at the top of the address space.
  assign o_pcplus4 = i_pc + AW'(PC_STEP);

  // Word offset scaled to bytes; the top two immediate bits fall off, which
  // gives the modulo-2^AW branch arithmetic.
  assign w_br_off  = $signed(i_signimm) <<< 2;
  assign w_br_tgt  = o_pcplus4 + $unsigned(w_br_off);

  // Jump keeps the 256 MB region of the delay-free successor.
  assign w_jmp_tgt = {o_pcplus4[AW-1:AW-4], i_instr_index, 2'b00};

  // Target mux, jump > branch > sequential.
  always_comb begin
    o_next_pc = o_pcplus4;
    if (i_jump) begin
      o_next_pc = w_jmp_tgt;
    end else if (i_pcsrc) begin
      o_next_pc = w_br_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch for the single-cycle controller: owns the PC, issues one
// request at a time to instruction memory, holds the returned word for decode
// and advances the PC when decode accepts it.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          pcsrc,
  input  logic          jump,
  input  logic [31:0]   signimm,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pcplus4,
  output logic [31:0]   retired
);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_retired;

  logic [AW-1:0] w_next_pc;
  logic          w_accept;
  logic          w_capture;

  next_pc_sel #(
    .AW (AW)
  ) u_next_pc_sel (
    .i_pc          (r_pc),
    .i_instr_index (r_instr[25:0]),
    .i_jump        (jump),
    .i_pcsrc       (pcsrc),
    .i_signimm     (signimm),
    .o_pcplus4     (pcplus4),
    .o_next_pc     (w_next_pc)
  );

  // Request is masked during reset so a reset landing in FETCH never looks
  // like a live request to memory.
  assign imem_req    = (r_state == FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == HOLD);
  assign pc          = r_pc;
  assign retired     = r_retired;

  // A response only counts while requesting; one in HOLD is stray and dropped.
  assign w_capture   = (r_state == FETCH) && imem_valid;
  assign w_accept    = (r_state == HOLD) && instr_ready;

  // FETCH waits for the word, HOLD waits for decode to take it and then
  // steers the PC; reset abandons whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
        r_state <= HOLD;
      end
      if (w_accept) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
        r_state   <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder with programmable wait,
// a transaction-level model of fetch/hold/accept checked every cycle, and
// literal expectations for the key addresses and counters.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  int wait_n = 0;
  int wcnt   = 0;
  bit spur   = 1'b0;
  logic [31:0] mem [logic [31:0]];

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic [31:0] m_seq;
  logic        m_have;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .AW       (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .retired     (retired)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0020;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got no event, expected one within 20 cycles", nm);
  endtask

  // Advance to the drive point of the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_hold(input string nm);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!instr_valid) tmo(nm);
  endtask

  task automatic accept(input logic j, input logic p, input logic [31:0] imm);
    wait_hold("accept_wait");
    instr_ready = 1'b1;
    jump        = j;
    pcsrc       = p;
    signimm     = imm;
    step();
    instr_ready = 1'b0;
    {jump, pcsrc} = 2'($urandom);
    signimm     = $urandom;
  endtask

  // Instruction memory: answers after wait_n idle request cycles; spur
  // injects a stray valid whenever nothing is being requested.
  initial forever begin
    @(posedge clk);
    #2;
    if (imem_req) begin
      if (wcnt >= wait_n) begin
        imem_valid = 1'b1;
        imem_rdata = rd(imem_addr);
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0BAD_F00D;
        wcnt++;
      end
    end else begin
      wcnt       = 0;
      imem_valid = spur;
      imem_rdata = 32'hDEAD_BEEF;
    end
  end

  // Model: either waiting for a word at m_pc or holding m_instr for decode.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_pc      = 32'h0;
      m_have    = 1'b0;
      m_instr   = 32'h0;
      m_retired = 32'h0;
      chk_en    = 1'b1;
    end else if (!m_have) begin
      if (imem_valid) begin
        m_instr = imem_rdata;
        m_have  = 1'b1;
      end
    end else if (instr_ready) begin
      m_seq     = m_pc + 32'd4;
      m_retired = m_retired + 32'd1;
      m_have    = 1'b0;
      if (jump)       m_pc = {m_seq[31:28], m_instr[25:0], 2'b00};
      else if (pcsrc) m_pc = m_seq + signimm * 32'd4;
      else            m_pc = m_seq;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(!reset && !m_have));
      if (!reset && !m_have) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      chk("instr", instr, m_instr);
      chk("pc", pc, m_pc);
      chk("pcplus4", pcplus4, m_pc + 32'd4);
      chk("retired", retired, m_retired);
    end
  end

  initial begin
    reset = 1'b1; instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
    mem[32'h0000_0000] = 32'h0000_0020;
    mem[32'h1000_0004] = 32'h0800_0010;
    step();
    step();
    @(negedge clk);
    chk("req_in_reset", 32'(imem_req), 32'd0);

    // zero-wait, decode always ready: one instruction per two cycles
    step();
    reset = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    step(); @(negedge clk);
    chk("t1_ivalid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h0000_0020);
    step(); @(negedge clk);
    chk("t1_addr4", imem_addr, 32'h4);
    step(); step(); @(negedge clk);
    chk("t1_addr8", imem_addr, 32'h8);
    step(); step();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("t1_addr12", imem_addr, 32'hC);
    chk("t1_retired3", retired, 32'd3);
    chk("model_retired3", m_retired, 32'd3);

    // three-cycle memory wait at address 0
    step();
    wait_n = 3;
    mem[32'h0000_0000] = 32'h8C01_0004;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_req_held", 32'(imem_req), 32'd1);
      chk("t2_addr_held", imem_addr, 32'h0);
      chk("t2_pc_held", pc, 32'h0);
      chk("t2_no_valid", 32'(instr_valid), 32'd0);
      step();
    end
    @(negedge clk);
    chk("t2_ivalid_rise", 32'(instr_valid), 32'd1);

    // hold lw for five cycles with stray memory responses
    spur = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {jump, pcsrc} = 2'($urandom);
      signimm = $urandom;
      @(negedge clk);
      chk("t3_instr_stable", instr, 32'h8C01_0004);
      chk("t3_no_req", 32'(imem_req), 32'd0);
      chk("t3_pc_stable", pc, 32'h0);
      step();
    end
    spur = 1'b0;
    wait_n = 0;

    // sequential, branch back, branch not taken, far branch, jump, wrap
    accept(1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("seq_addr4", imem_addr, 32'h4);
    accept(1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("seq_addr8", imem_addr, 32'h8);
    accept(1'b0, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk); chk("branch_back", imem_addr, 32'h4);
    accept(1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("seq_addr8b", imem_addr, 32'h8);
    accept(1'b0, 1'b0, 32'hFFFF_FFFE);
    @(negedge clk); chk("branch_not_taken", imem_addr, 32'hC);
    accept(1'b0, 1'b1, 32'h03FF_FFFD);
    @(negedge clk); chk("branch_far", imem_addr, 32'h1000_0004);
    accept(1'b1, 1'b1, 32'h0000_0123);
    @(negedge clk);
    chk("jump_wins", imem_addr, 32'h1000_0040);
    chk("model_jump", m_pc, 32'h1000_0040);
    accept(1'b0, 1'b1, 32'h3BFF_FFEE);
    @(negedge clk);
    chk("branch_top", imem_addr, 32'hFFFF_FFFC);
    chk("pcplus4_wrap", pcplus4, 32'h0);
    accept(1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("seq_wrap", imem_addr, 32'h0);

    // reset while holding with retired = 7
    step();
    do_reset();
    for (int i = 0; i < 7; i++) accept(1'b0, 1'b0, 32'h0);
    wait_hold("hold_before_reset");
    @(negedge clk);
    chk("retired7", retired, 32'd7);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("req_off_in_reset", 32'(imem_req), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("hold_rst_pc", pc, 32'h0);
    chk("hold_rst_ivalid", 32'(instr_valid), 32'd0);
    chk("hold_rst_retired", retired, 32'd0);
    chk("hold_rst_addr", imem_addr, 32'h0);

    // reset in the middle of a waiting fetch, with a valid during reset
    wait_n = 5;
    accept(1'b0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b1;
    spur  = 1'b1;
    step();
    reset  = 1'b0;
    spur   = 1'b0;
    wait_n = 0;
    @(negedge clk);
    chk("fetch_rst_addr", imem_addr, 32'h0);
    chk("fetch_rst_retired", retired, 32'd0);
    chk("fetch_rst_ivalid", 32'(instr_valid), 32'd0);
    step();
    @(negedge clk);
    chk("no_stale", instr, 32'h8C01_0004);
    chk("no_stale_valid", 32'(instr_valid), 32'd1);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-supply side of the single-cycle controller interface.
- Owns the PC and fetches 32-bit words from instruction memory through a valid handshake.
- Presents each word to decode (op = instr[31:26], funct = instr[5:0]).
- Consumes the controller's pcsrc/jump resolution plus the sign-extended immediate to choose the next PC.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- AW, 32, PC/address width; fixed at 32 for this core.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  32  fetch address, equals pc while imem_req.
- imem_valid  in  1  read data valid; may assert in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_valid.
- instr  out  32  registered instruction for decode.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decode/execute accepts instr this cycle.
- pcsrc  in  1  controller branch-taken, meaningful only on accept.
- jump  in  1  controller jump, meaningful only on accept.
- signimm  in  32  sign-extended immediate of instr, meaningful only on accept.
- pc  out  32  address of the current/held instruction.
- pcplus4  out  32  pc + 4, for jal/link users.
- retired  out  32  count of accepted instructions.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, retired=0. imem_req=1 from the first cycle after reset deasserts.
- imem_req is 0 during reset cycles.
- State FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_valid: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Otherwise stay; pc and address are stable.
- State HOLD:
  - imem_req=0, instr_valid=1, instr stable.
  - On instr_ready (accept): compute next PC, retired<=retired+1 (wraps at 2^32), instr_valid<=0, go to FETCH.
  - Otherwise stay; instr is unchanged.
- Next PC on accept, priority jump > pcsrc > sequential:
  - jump: {pcplus4[31:28], instr[25:0], 2'b00}.
  - pcsrc: pcplus4 + (signimm << 2), modulo 2^32.
  - else: pcplus4.
- pcplus4 = pc + 4, combinational, wraps 32'hFFFFFFFC -> 0.
- pcsrc, jump and signimm are ignored outside the accept cycle. jump=pcsrc=1 together resolves as jump.
- Latency:
  - Zero-wait memory with instr_ready tied high: one instruction per 2 cycles.
  - Memory wait of N cycles adds N cycles.
  - Accept-to-next-request is 1 cycle.
- Only one outstanding request. No prefetch, so no squash is needed on a taken branch.
- Reset mid-operation:
  - Pending fetch abandoned; any imem_valid in the reset cycle is ignored.
  - Held instr dropped; pc restarts at RESET_PC.
  - Instruction memory shares the same reset, so no stale response arrives afterwards.
- imem_valid while not requesting (HOLD) is ignored.
- No alignment checking: targets are word-aligned by construction. RESET_PC[1:0] is 0 by contract.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010.
  - PC_STEP=4.
  - fetch state enum {FETCH, HOLD}.
- One natural sub-module: next_pc_sel (combinational jump/branch/sequential target mux and adders), reusable by a later pipelined fetch.

Test Plan:
- Reset with RESET_PC=0; release; zero-wait memory returns 32'h00000020 (add); instr_ready=1 -> imem_addr sequence 0,4,8 every 2 cycles; instr_valid pulses; retired=3 after 3 accepts.
- Memory wait 3 cycles at addr 0 -> imem_req and imem_addr=0 held 4 cycles; instr_valid rises the cycle after imem_valid; pc stays 0.
- Hold instr 32'h8C010004 (lw) with instr_ready=0 for 5 cycles -> instr stable, imem_req=0, pc unchanged; imem_valid pulses ignored.
- Branch at pc=8: accept with pcsrc=1, signimm=32'hFFFFFFFE -> next imem_addr = 12 - 8 = 4. Same with pcsrc=0 -> 12.
- Jump at pc=32'h10000004, instr=32'h08000010, jump=1, pcsrc=1 -> next imem_addr=32'h10000040 (jump wins).
- Assert reset while in HOLD with retired=7 and again mid-FETCH with a pending wait -> next cycle pc=RESET_PC, instr_valid=0, retired=0; fetch resumes at RESET_PC; no stale instruction delivered.
